// File: rtl/stopwatch_display.sv
// stopwatch_display: four-digit multiplexed common-anode seven-segment driver.
// Scans one digit per refresh slot, snapshots the BCD time once per frame so a
// rollover never tears the shown value, and blinks the selected pair in adjust.
`timescale 1ns/1ps
module stopwatch_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] min_ten,
  input  logic [3:0] min_unit,
  input  logic [2:0] sec_ten,
  input  logic [3:0] sec_unit,
  input  logic       adjust,
  input  logic       select,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DW-1:0]   r_div_cnt;
  logic [1:0]      r_idx;
  logic [3:0][3:0] r_snap;      // [3]=min_ten .. [0]=sec_unit
  logic [BW-1:0]   r_blink_cnt;
  logic            r_blink_off;

  logic            w_div_tc;
  logic            w_blink_tc;
  logic [3:0]      w_digit;
  logic [6:0]      w_seg_dec;
  logic            w_blank;

  assign w_div_tc   = (r_div_cnt == DW'(REFRESH_DIV - 1));
  assign w_blink_tc = (r_blink_cnt == BW'(BLINK_DIV - 1));

  // Active-low seven-segment decode {g,f,e,d,c,b,a}; 10..15 show a dash.
  function automatic logic [6:0] decode_digit(input logic [3:0] d);
    case (d)
      4'd0:    decode_digit = 7'b1000000;
      4'd1:    decode_digit = 7'b1111001;
      4'd2:    decode_digit = 7'b0100100;
      4'd3:    decode_digit = 7'b0110000;
      4'd4:    decode_digit = 7'b0011001;
      4'd5:    decode_digit = 7'b0010010;
      4'd6:    decode_digit = 7'b0000010;
      4'd7:    decode_digit = 7'b1111000;
      4'd8:    decode_digit = 7'b0000000;
      4'd9:    decode_digit = 7'b0010000;
      default: decode_digit = 7'b0111111;
    endcase
  endfunction

  // Refresh divider, scan index and frame snapshot of the four input digits.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_idx     <= 2'd0;
      r_snap    <= '0;
    end else begin
      r_div_cnt <= w_div_tc ? '0 : r_div_cnt + DW'(1);
      if (w_div_tc) begin
        r_idx <= r_idx + 2'd1;  // 3 wraps to 0 at the frame boundary
        if (r_idx == 2'd3)
          r_snap <= {{1'b0, min_ten}, min_unit, {1'b0, sec_ten}, sec_unit};
      end
    end
  end

  // Blink timer: runs only in adjust mode, cleared the moment adjust drops so
  // re-entry always starts with a fully visible half-period.
  always_ff @(posedge clock) begin
    if (reset || !adjust) begin
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else begin
      r_blink_cnt <= w_blink_tc ? '0 : r_blink_cnt + BW'(1);
      if (w_blink_tc)
        r_blink_off <= ~r_blink_off;
    end
  end

  // Current digit, its decode and whether it falls in the blanked pair.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_digit   = r_snap[r_idx];
    w_seg_dec = decode_digit(w_digit);
    w_blank   = 1'b0;
    if (adjust && r_blink_off)
      w_blank = select ? ~r_idx[1] : r_idx[1];  // idx 3,2 = minutes; 1,0 = seconds
  end

  // Registered display pins; the anode pattern and dp ignore blanking.
  always_ff @(posedge clock) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << r_idx);
      seg <= w_blank ? 7'b1111111 : w_seg_dec;
      dp  <= (r_idx != 2'd2);
    end
  end

endmodule

// File: tb/tb_stopwatch_display.sv
// Testbench for stopwatch_display with a cycle-count based reference model.
`timescale 1ns/1ps
module tb_stopwatch_display;

  localparam int R = 4;
  localparam int B = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] min_ten, sec_ten;
  logic [3:0] min_unit, sec_unit;
  logic       adjust, select;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  stopwatch_display #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clock(clock), .reset(reset),
    .min_ten(min_ten), .min_unit(min_unit), .sec_ten(sec_ten), .sec_unit(sec_unit),
    .adjust(adjust), .select(select),
    .an(an), .seg(seg), .dp(dp)
  );

  // Reference decode straight from the segment table.
  function automatic logic [6:0] ref_seg(input int v);
    case (v)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b0111111;
    endcase
  endfunction

  // Model: m_cyc = edges since reset release, m_arun = consecutive adjust edges.
  // Slot, frame boundary and blink phase follow from plain division.
  int         m_cyc, m_arun, m_slot;
  int         m_snap [4];
  bit         m_blank;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  always @(posedge clock) begin
    if (reset) begin
      m_cyc = 0; m_arun = 0;
      for (int i = 0; i < 4; i++) m_snap[i] = 0;
      exp_an = 4'b1111; exp_seg = 7'b1111111; exp_dp = 1'b1;
    end else begin
      m_slot  = (m_cyc / R) % 4;
      m_blank = adjust && ((m_arun / B) % 2 == 1) && (select ? (m_slot < 2) : (m_slot >= 2));
      exp_an  = 4'b1111 & ~(4'b0001 << m_slot);
      exp_seg = m_blank ? 7'b1111111 : ref_seg(m_snap[m_slot]);
      exp_dp  = (m_slot == 2) ? 1'b0 : 1'b1;
      if (m_cyc % (4 * R) == 4 * R - 1) begin
        m_snap[3] = int'(min_ten);  m_snap[2] = int'(min_unit);
        m_snap[1] = int'(sec_ten);  m_snap[0] = int'(sec_unit);
      end
      m_cyc++;
      m_arun = adjust ? m_arun + 1 : 0;
    end
  end

  task automatic set_digits(input int mt, input int mu, input int st, input int su);
    min_ten = 3'(mt); min_unit = 4'(mu); sec_ten = 3'(st); sec_unit = 4'(su);
  endtask

  task automatic test_reset();
    reset = 1'b1; adjust = 1'b0; select = 1'b0;
    set_digits(1, 2, 3, 4);
    repeat (3) begin
      @(negedge clock); n_cmp++;
      if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
        n_bad++; $display("FAIL reset_hold: an=%b seg=%b dp=%b want 1111 1111111 1", an, seg, dp);
      end
    end
    reset = 1'b0;
    @(negedge clock); n_cmp++;
    if ({an, seg, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      n_bad++; $display("FAIL first_cycle: an=%b seg=%b dp=%b want 1110 1000000 1", an, seg, dp);
    end
    repeat (47) begin
      @(negedge clock); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_bad++; $display("FAIL scan: an=%b seg=%b dp=%b want %b %b %b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_snapshot();
    bit changed = 1'b0;
    set_digits(0, 9, 5, 9);
    for (int i = 0; i < 90; i++) begin
      @(negedge clock); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_bad++; $display("FAIL snapshot: an=%b seg=%b dp=%b want %b %b %b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (!changed && i > 34 && (m_cyc % (4 * R)) == R) begin
        set_digits(1, 0, 0, 0);  // mid-frame, scan index 1
        changed = 1'b1;
      end
    end
    n_cmp++;
    if (!changed) begin
      n_bad++; $display("FAIL snapshot_trigger: changed=%0d want 1", changed);
    end
  endtask

  task automatic test_decode();
    for (int v = 0; v < 16; v++) begin
      sec_unit = 4'(v);
      repeat (4 * R) begin
        @(negedge clock); n_cmp++;
        if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
          n_bad++; $display("FAIL decode_%0d: an=%b seg=%b dp=%b want %b %b %b", v, an, seg, dp, exp_an, exp_seg, exp_dp);
        end
      end
    end
    sec_ten = 3'd6; min_ten = 3'd7;
    repeat (8 * R) begin
      @(negedge clock); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_bad++; $display("FAIL decode_tens: an=%b seg=%b dp=%b want %b %b %b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    // Direct look at the last frame's tens slots.
    repeat (4 * R) begin
      @(negedge clock);
      if (an === 4'b1101) begin
        n_cmp++;
        if (seg !== 7'b0000010) begin n_bad++; $display("FAIL sec_ten_6: seg=%b want 0000010", seg); end
      end
      if (an === 4'b0111) begin
        n_cmp++;
        if (seg !== 7'b1111000) begin n_bad++; $display("FAIL min_ten_7: seg=%b want 1111000", seg); end
      end
    end
  endtask

  task automatic test_blink_minutes();
    int blanks = 0;
    set_digits(2, 3, 4, 5);
    adjust = 1'b1; select = 1'b0;
    repeat (5 * B) begin
      @(negedge clock); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_bad++; $display("FAIL blink_min: an=%b seg=%b dp=%b want %b %b %b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if (seg === 7'b1111111) blanks++;
    end
    n_cmp++;
    if (blanks == 0) begin
      n_bad++; $display("FAIL blink_min_seen: blanks=%0d want >0", blanks);
    end
  endtask

  task automatic test_blink_switch();
    int guard = 0;
    while (!(((m_arun / B) % 2 == 1) && adjust) && guard < 4 * B) begin
      @(negedge clock); guard++; n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_bad++; $display("FAIL switch_wait: an=%b seg=%b dp=%b want %b %b %b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    n_cmp++;
    if (guard >= 4 * B) begin n_bad++; $display("FAIL switch_timeout: waited=%0d want <%0d", guard, 4 * B); end
    select = 1'b1;
    repeat (10) begin
      @(negedge clock); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_bad++; $display("FAIL switch_sel: an=%b seg=%b dp=%b want %b %b %b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
    adjust = 1'b0;
    repeat (40) begin
      @(negedge clock); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp} || seg === 7'b1111111) begin
        n_bad++; $display("FAIL switch_exit: an=%b seg=%b dp=%b want %b %b %b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    adjust = 1'b1; select = 1'b0;
    repeat (B + 3) @(negedge clock);
    while ((m_cyc % (4 * R)) != 2 * R + 2 && guard < 40) begin
      @(negedge clock); guard++;
    end
    n_cmp++;
    if (guard >= 40) begin n_bad++; $display("FAIL reset_mid_timeout: waited=%0d want <40", guard); end
    reset = 1'b1;
    @(negedge clock); n_cmp++;
    if ({an, seg, dp, dut.r_blink_off, dut.r_idx} !== {4'b1111, 7'b1111111, 1'b1, 1'b0, 2'd0}) begin
      n_bad++; $display("FAIL reset_mid: an=%b seg=%b dp=%b boff=%b idx=%0d want 1111 1111111 1 0 0",
                        an, seg, dp, dut.r_blink_off, dut.r_idx);
    end
    reset = 1'b0;
    @(negedge clock); n_cmp++;
    if (an !== 4'b1110) begin n_bad++; $display("FAIL reset_restart: an=%b want 1110", an); end
    repeat (40) begin
      @(negedge clock); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_bad++; $display("FAIL reset_after: an=%b seg=%b dp=%b want %b %b %b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  endtask

  task automatic test_random();
    repeat (800) begin
      @(negedge clock); n_cmp++;
      if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
        n_bad++; $display("FAIL random: an=%b seg=%b dp=%b want %b %b %b", an, seg, dp, exp_an, exp_seg, exp_dp);
      end
      if ($urandom_range(7) == 0)
        set_digits($urandom_range(7), $urandom_range(15), $urandom_range(7), $urandom_range(15));
      if ($urandom_range(39) == 0) adjust = ~adjust;
      if ($urandom_range(19) == 0) select = ~select;
    end
  endtask

  initial begin
    reset = 1'b1; adjust = 1'b0; select = 1'b0;
    set_digits(0, 0, 0, 0);
    test_reset();
    test_snapshot();
    test_decode();
    test_blink_minutes();
    test_blink_switch();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Four-digit multiplexed seven-segment driver that consumes the stopwatch's BCD time digits (min_ten, min_unit, sec_ten, sec_unit) and drives a common-anode 4-digit display. It sits between the stopwatch counter and the board's display pins. It scans one digit per refresh slot and snapshots all four digits at each frame boundary, so a digit rollover cannot tear the displayed value. In adjust mode it blinks the selected minutes or seconds pair.

## Interface
- REFRESH_DIV, 100000: clock cycles each digit is driven, ≥2.
- BLINK_DIV, 25000000: clock cycles per blink half-period, ≥2.
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- min_ten  input  3  minutes tens digit, binary 0–5 nominal.
- min_unit  input  4  minutes units digit, BCD.
- sec_ten  input  3  seconds tens digit, binary 0–5 nominal.
- sec_unit  input  4  seconds units digit, BCD.
- adjust  input  1  1 = adjust mode, blink the selected pair.
- select  input  1  0 = minutes pair selected, 1 = seconds pair selected.
- an  output  4  digit enables, active-low. an[3]=min_ten, an[2]=min_unit, an[1]=sec_ten, an[0]=sec_unit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

## Operation
- **Refresh divider:** div_cnt counts 0..REFRESH_DIV-1 and wraps. At terminal count, scan index idx advances 0→1→2→3→0. idx k selects an[k].
- **Frame snapshot:** on the cycle where div_cnt is terminal and idx==3, all four inputs are latched together and idx becomes 0. Inputs are ignored at all other times.
- **Tens inputs:** zero-extended to 4 bits before decoding.
- **Decode (active-low):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10–15 = dash 0111111. A tens value of 6 or 7 is a legal digit and decodes as 6 or 7.
- **Decimal point:** dp=0 only while an[2] is active (MM.SS separator); otherwise dp=1. The dp is never blanked.
- **Blink:** while adjust=1, blink_cnt counts 0..BLINK_DIV-1 and blink_off toggles at terminal count.
  - While adjust=0, blink_cnt and blink_off are held at 0.
  - Blanked digits: when adjust=1 and blink_off=1, digits of the selected pair output seg=1111111. select=0 blanks an[3] and an[2]; select=1 blanks an[1] and an[0].
  - The an pattern is unchanged by blanking.
- adjust and select are sampled every cycle, not frame-latched.

## Timing
- **Reset values:** an=1111, seg=1111111, dp=1, idx=0, div_cnt=0, blink_cnt=0, blink_off=0, snapshot=0/0/0/0.
- **Registered outputs:** an, seg and dp are registered from idx, the snapshot and blink state, with 1-cycle latency.
  - First cycle after reset deasserts: an=1110, seg=1000000 (snapshot digit 0).
- **Scan period:** each digit is enabled for exactly REFRESH_DIV cycles. A full frame is 4·REFRESH_DIV cycles. Exactly one an bit is low at any time after the first post-reset cycle.
- **Display latency:**
  - Until the first frame boundary, the display shows 00.00.
  - New input values appear no later than 4·REFRESH_DIV+1 cycles after they are applied.
  - A change applied on the snapshot cycle itself is captured.
- **Simultaneous events:** if a frame boundary and a blink toggle fall on the same cycle, both take effect. Blanking uses the new blink_off value from the next cycle on.
- **Adjust entry:** on adjust 0→1, the selected pair is visible for the first full BLINK_DIV cycles.
- **Adjust exit:** on adjust 1→0, blanking stops on the next output update (1 cycle).
- **Reset mid-frame:** reset asserted at any point returns all state to reset values on the next edge. No partial frame is completed.

## Test plan
Use REFRESH_DIV=4 and BLINK_DIV=16 for all scenarios.
- **Reset/scan:** assert reset 3 cycles, then release with inputs 1/2/3/4. Required: an=1111 during reset; 00.00 for the first 16 cycles; then the frame shows an[3]→seg 1111001, an[2]→0100100 with dp=0, an[1]→0110000, an[0]→0011001; each an low for exactly 4 cycles, in the order an[0],an[1],an[2],an[3].
- **Snapshot atomicity:** present 0/9/5/9. Change to 1/0/0/0 mid-frame (idx=1). Required: the current frame continues to show 09.59; the next frame shows 10.00; no mixed value appears.
- **Full decode:** sweep sec_unit 0–15 across frames. Required: the an[0] slot shows each listed pattern, and values 10–15 show 0111111. Set sec_ten=6 and min_ten=7: required 0000010 and 1111000.
- **Blink minutes:** inputs 2/3/4/5, adjust=1, select=0. Required: an[3]/an[2] show digits for 16 cycles, then seg=1111111 for 16 cycles while an still cycles and dp stays 0 on an[2]; an[1]/an[0] are never blanked.
- **Blink exit/select switch:** during a blanked phase, switch select 0→1 and then drop adjust. Required: the minutes pair reappears and the seconds pair blanks within 1 cycle; after adjust=0, no digit is blank from the next cycle on.
- **Reset mid-operation:** assert reset at idx=2, div_cnt=2 with adjust=1. Required: the next cycle has all outputs at reset values and blink_off=0; after release, the scan restarts from an[0].
